// File: rtl/lfsr_2bit_random.sv
// ---------------------------------------------------------------------------
// lfsr_2bit_random
//
// Pseudo-random 2-bit value generator for the game logic. Two free-running
// LFSRs advance in the clk domain: LFSR A (16 bit) every cycle and LFSR B
// (15 bit) once every SLOW_DIV cycles. A synchronized rising edge on
// button_pressed captures a 2-bit mix of both LFSRs into rnd, which then holds
// until the next press.
//
// Parameters:
//   SEED_A   - reset value of LFSR A (0 is replaced by 16'h0001)
//   SEED_B   - reset value of LFSR B (0 is replaced by 15'h0001)
//   SLOW_DIV - LFSR B advance period in clk cycles, legal range 1..255
//
// Ports:
//   clk            in   system clock, all state updates on its rising edge
//   rst_n          in   synchronous reset, active HIGH despite the name
//   button_pressed in   asynchronous button level
//   rnd            out  registered random value, latched on each press
//   rnd_valid      out  (only with LFSR_RNG_VALID_EN defined) one-cycle pulse
//                       coincident with each new rnd value
//
// Optional feature macro: LFSR_RNG_VALID_EN
// ---------------------------------------------------------------------------
module lfsr_2bit_random #(
    parameter logic [15:0] SEED_A   = 16'hACE1,
    parameter logic [14:0] SEED_B   = 15'h1234,
    parameter int unsigned SLOW_DIV = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_pressed,
    output logic [1:0] rnd
`ifdef LFSR_RNG_VALID_EN
    ,
    output logic       rnd_valid
`endif
);

    // An all-zero seed would lock the LFSR, so substitute 1.
    localparam logic [15:0] RST_A    = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
    localparam logic [14:0] RST_B    = (SEED_B == 15'h0000) ? 15'h0001 : SEED_B;
    localparam logic [7:0]  DIV_LAST = 8'(SLOW_DIV - 1);

    logic [15:0] lfsr_a_q, lfsr_a_d;
    logic [14:0] lfsr_b_q, lfsr_b_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sync1_q, sync2_q, edge_q;
    logic [1:0]  rnd_q, rnd_d;
    logic        fb_a, fb_b;
    logic        div_last;
    logic        press;

    always_comb begin
        fb_a     = lfsr_a_q[15] ^ lfsr_a_q[13] ^ lfsr_a_q[12] ^ lfsr_a_q[10];
        fb_b     = lfsr_b_q[14] ^ lfsr_b_q[13];
        div_last = (div_cnt_q == DIV_LAST);
        press    = sync2_q & ~edge_q;

        div_cnt_d = div_last ? 8'd0 : div_cnt_q + 8'd1;

        // Lock-up guard: an all-zero register reloads 1 instead of shifting.
        lfsr_a_d = (lfsr_a_q == 16'h0000) ? 16'h0001 : {lfsr_a_q[14:0], fb_a};

        lfsr_b_d = lfsr_b_q;
        if (lfsr_b_q == 15'h0000) begin
            lfsr_b_d = 15'h0001;
        end else if (div_last) begin
            lfsr_b_d = {lfsr_b_q[13:0], fb_b};
        end

        // Mix uses the current (pre-update) register values.
        rnd_d = rnd_q;
        if (press) begin
            rnd_d = {lfsr_a_q[15] ^ lfsr_b_q[14], lfsr_a_q[0] ^ lfsr_b_q[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lfsr_a_q  <= RST_A;
            lfsr_b_q  <= RST_B;
            div_cnt_q <= 8'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            rnd_q     <= 2'b00;
        end else begin
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            div_cnt_q <= div_cnt_d;
            sync1_q   <= button_pressed;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            rnd_q     <= rnd_d;
        end
    end

    assign rnd = rnd_q;

`ifdef LFSR_RNG_VALID_EN
    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= press;
        end
    end

    assign rnd_valid = valid_q;
`endif

endmodule

// File: tb/tb_lfsr_2bit_random.sv
// ---------------------------------------------------------------------------
// tb_lfsr_2bit_random
//
// Directed bench for lfsr_2bit_random. A main instance uses the default
// parameters; a second instance uses zero seeds and SLOW_DIV=1 to cover seed
// substitution and the every-cycle B advance. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Press timing is derived from
// the stimulus schedule; expected capture values come from a spec-level LFSR
// model of the default instance.
// ---------------------------------------------------------------------------
module tb_lfsr_2bit_random;

    logic       clk;
    logic       rst_n;
    logic       button;
    logic [1:0] rnd;
    logic [1:0] rnd1;
`ifdef LFSR_RNG_VALID_EN
    logic       rnd_valid;
    logic       rnd_valid1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference LFSR state of the default instance.
    logic [15:0] ma;
    logic [14:0] mb;
    int          mdiv;

    logic [3:0] seen;

    lfsr_2bit_random dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .button_pressed (button),
        .rnd            (rnd)
`ifdef LFSR_RNG_VALID_EN
        ,
        .rnd_valid      (rnd_valid)
`endif
    );

    lfsr_2bit_random #(
        .SEED_A   (16'h0000),
        .SEED_B   (15'h0000),
        .SLOW_DIV (1)
    ) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .button_pressed (button),
        .rnd            (rnd1)
`ifdef LFSR_RNG_VALID_EN
        ,
        .rnd_valid      (rnd_valid1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            ma   <= 16'hACE1;
            mb   <= 15'h1234;
            mdiv <= 0;
        end else begin
            ma   <= {ma[14:0], ma[15] ^ ma[13] ^ ma[12] ^ ma[10]};
            mdiv <= (mdiv == 2) ? 0 : mdiv + 1;
            if (mdiv == 2) begin
                mb <= {mb[13:0], mb[14] ^ mb[13]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Starts a press at the current falling edge: button high for hi edges,
    // then low, for hi+lo edges in total. The first high sample is edge k;
    // rnd must stay put through k+1, change at k+2 and hold afterwards.
    task automatic do_press(input int hi, input int lo, input bit rel_rst, input string tag);
        logic [1:0] prev;
        logic [1:0] exp;
        prev   = rnd;
        exp    = prev;
        button = 1'b1;
        if (rel_rst) begin
            rst_n = 1'b0;
        end
        for (int j = 0; j < hi + lo; j++) begin
            @(negedge clk);
            if (j < 2) begin
                check({tag, "_before"}, 32'(rnd), 32'(prev));
            end else begin
                check({tag, "_capture"}, 32'(rnd), 32'(exp));
            end
`ifdef LFSR_RNG_VALID_EN
            check({tag, "_valid"}, 32'(rnd_valid), (j == 2) ? 32'd1 : 32'd0);
`endif
            if (j == 1) begin
                exp = {ma[15] ^ mb[14], ma[0] ^ mb[0]};
            end
            button = (j + 1 < hi);
        end
    endtask

    initial begin
        button = 1'b0;
        rst_n  = 1'b1;
        seen   = 4'h0;
        repeat (2) @(negedge clk);

        // Reset values, including zero-seed substitution on dut1.
        check("rst_rnd", 32'(rnd), 32'd0);
        check("rst_a", 32'(dut.lfsr_a_q), 32'h0000ACE1);
        check("rst_b", 32'(dut.lfsr_b_q), 32'h00001234);
        check("rst_a_zero_seed", 32'(dut1.lfsr_a_q), 32'h00000001);
        check("rst_b_zero_seed", 32'(dut1.lfsr_b_q), 32'h00000001);
        check("rst_rnd1", 32'(rnd1), 32'd0);
`ifdef LFSR_RNG_VALID_EN
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_valid1", 32'(rnd_valid1), 32'd0);
`endif

        rst_n = 1'b0;
        @(negedge clk);
        check("a_step1", 32'(dut.lfsr_a_q), 32'h000059C3);
        check("b_hold1", 32'(dut.lfsr_b_q), 32'h00001234);
        check("a1_step1", 32'(dut1.lfsr_a_q), 32'h00000002);
        check("b1_step1", 32'(dut1.lfsr_b_q), 32'h00000002);
        @(negedge clk);
        check("b_hold2", 32'(dut.lfsr_b_q), 32'h00001234);
        check("b1_step2", 32'(dut1.lfsr_b_q), 32'h00000004);
        @(negedge clk);
        check("b_step3", 32'(dut.lfsr_b_q), 32'h00002468);

        // Idle: no captures, LFSRs follow the model.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("idle_rnd", 32'(rnd), 32'd0);
            check("idle_a", 32'(dut.lfsr_a_q), 32'(ma));
            check("idle_b", 32'(dut.lfsr_b_q), 32'(mb));
        end
        check("b_step6", 32'(dut.lfsr_b_q), 32'(mb));

        // Single press, then a long hold period.
        do_press(3, 100, 1'b0, "single");
        seen[rnd] = 1'b1;

        // Held button: exactly one capture, constant while held.
        do_press(50, 20, 1'b0, "held");
        seen[rnd] = 1'b1;

        // Repeated presses, 3 high / 4 low.
        for (int p = 0; p < 64; p++) begin
            do_press(3, 4, 1'b0, "repeat");
            seen[rnd] = 1'b1;
        end
        check("all_values_seen", 32'(seen), 32'h0000000F);

        // Reset while the button is high; release with it still high.
        button = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midpress_rst_rnd", 32'(rnd), 32'd0);
        check("midpress_rst_a", 32'(dut.lfsr_a_q), 32'h0000ACE1);
`ifdef LFSR_RNG_VALID_EN
        check("midpress_rst_valid", 32'(rnd_valid), 32'd0);
`endif
        do_press(3, 10, 1'b1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
